sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 215 +++++++++++++++++++++
 tb/tb_sdram_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: 4 banks, mode register, refresh counter,
// sequential wrapping bursts and a CAS-latency read pipeline over a synchronous RAM.
module sdram_responder #(
    parameter int CL_DEFAULT = 2,
    parameter int ROW_BITS   = 4,
    parameter int COL_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras,
    input  logic        sdram_cas,
    input  logic        sdram_we,
    input  logic [1:0]  sdram_ba,
    input  logic [11:0] sdram_a,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        cmd_error,
    output logic [15:0] refresh_count
);
    localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_t;

    typedef enum logic {BANK_IDLE = 1'b0, BANK_ACTIVE = 1'b1} bank_t;

    bank_t               r_bank [4];
    bank_t               w_bank_nxt [4];
    logic [ROW_BITS-1:0] r_row [4];
    logic [1:0]          r_cl;
    logic [1:0]          r_bl_code;
    logic [15:0]         r_refresh;
    logic                r_cmd_err;
    logic                r_bst_active;
    logic                r_bst_wr;
    logic [2:0]          r_bst_idx;
    logic [1:0]          r_bst_bank;
    logic [ROW_BITS-1:0] r_bst_row;
    logic [COL_BITS-1:0] r_bst_col;
    logic                r_rd_vld_p1, r_rd_vld_p2, r_rd_vld_p3;
    logic [ADDR_W-1:0]   r_rd_addr_p1, r_rd_addr_p2, r_rd_addr_p3;
    logic [15:0]         r_mem [0:DEPTH-1];
    logic [15:0]         r_rdata;
    logic [15:0]         r_dq_out;
    logic                r_dq_oe;

    cmd_t                w_cmd;
    logic                w_any_active, w_sel_active;
    logic                w_act_ok, w_rw_ok, w_wr_start, w_ref_ok, w_mrs_vals_ok, w_mrs_ok;
    logic                w_pre_hits, w_bst_cont, w_err, w_bst_done;
    logic [2:0]          w_bl_mask;
    logic [COL_BITS-1:0] w_col_mask, w_col_off;
    logic                w_gen_vld, w_gen_wr;
    logic [ADDR_W-1:0]   w_gen_addr;
    logic                w_ram_re, w_due;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_unused;

    assign w_unused = &{1'b0, sdram_a};
    assign w_cmd    = sdram_cs_n ? CMD_NOP : cmd_t'({sdram_ras, sdram_cas, sdram_we});

    always_comb begin
        w_any_active = 1'b0;
        for (int b = 0; b < 4; b++)
            if (r_bank[b] == BANK_ACTIVE) w_any_active = 1'b1;
    end

    assign w_sel_active  = (r_bank[sdram_ba] == BANK_ACTIVE);
    assign w_act_ok      = (w_cmd == CMD_ACT) && !w_sel_active;
    assign w_rw_ok       = ((w_cmd == CMD_RD) || (w_cmd == CMD_WR)) && w_sel_active;
    assign w_wr_start    = w_rw_ok && (w_cmd == CMD_WR);
    assign w_ref_ok      = (w_cmd == CMD_REF) && !w_any_active;
    assign w_mrs_vals_ok = ((sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3)) && !sdram_a[2];
    assign w_mrs_ok      = (w_cmd == CMD_MRS) && !w_any_active && w_mrs_vals_ok;
    assign w_pre_hits    = (w_cmd == CMD_PRE) && r_bst_active &&
                           (sdram_a[10] || (sdram_ba == r_bst_bank));
    assign w_bst_cont    = r_bst_active && !(w_rw_ok || (w_cmd == CMD_BST) || w_pre_hits);
    assign w_err = ((w_cmd == CMD_ACT) && w_sel_active) ||
                   (((w_cmd == CMD_RD) || (w_cmd == CMD_WR)) && !w_sel_active) ||
                   ((w_cmd == CMD_REF) && w_any_active) ||
                   ((w_cmd == CMD_MRS) && !w_mrs_ok) ||
                   ((w_cmd == CMD_BST) && !r_bst_active);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_bank_nxt[b] = r_bank[b];
            if (w_cmd == CMD_PRE && (sdram_a[10] || sdram_ba == 2'(b)))
                w_bank_nxt[b] = BANK_IDLE;
            if (w_act_ok && sdram_ba == 2'(b))
                w_bank_nxt[b] = BANK_ACTIVE;
        end
    end

    always_comb begin
        case (r_bl_code)
            2'd0:    w_bl_mask = 3'd0;
            2'd1:    w_bl_mask = 3'd1;
            2'd2:    w_bl_mask = 3'd3;
            default: w_bl_mask = 3'd7;
        endcase
    end

    assign w_col_mask = COL_BITS'(w_bl_mask);
    assign w_col_off  = r_bst_col + COL_BITS'(r_bst_idx);
    assign w_bst_done = (r_bst_idx == w_bl_mask);

    // Word address generation: burst word 0 comes straight from the pins, later words from the burst state
    always_comb begin
        w_gen_vld  = 1'b0;
        w_gen_wr   = 1'b0;
        w_gen_addr = '0;
        if (w_rw_ok) begin
            w_gen_vld  = 1'b1;
            w_gen_wr   = (w_cmd == CMD_WR);
            w_gen_addr = {sdram_ba, r_row[sdram_ba], sdram_a[COL_BITS-1:0]};
        end else if (w_bst_cont) begin
            w_gen_vld  = 1'b1;
            w_gen_wr   = r_bst_wr;
            w_gen_addr = {r_bst_bank, r_bst_row,
                          (r_bst_col & ~w_col_mask) | (w_col_off & w_col_mask)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) r_bank[b] <= BANK_IDLE;
            r_cl         <= 2'(CL_DEFAULT);
            r_bl_code    <= 2'd0;
            r_refresh    <= 16'd0;
            r_cmd_err    <= 1'b0;
            r_bst_active <= 1'b0;
            r_bst_idx    <= 3'd0;
        end else begin
            for (int b = 0; b < 4; b++) r_bank[b] <= w_bank_nxt[b];
            r_cmd_err <= w_err;
            if (w_ref_ok) r_refresh <= r_refresh + 16'd1;
            if (w_mrs_ok) begin
                r_cl      <= sdram_a[5:4];
                r_bl_code <= sdram_a[1:0];
            end
            if (w_rw_ok) begin
                r_bst_active <= (r_bl_code != 2'd0);
                r_bst_idx    <= 3'd1;
            end else if (w_bst_cont) begin
                r_bst_idx <= r_bst_idx + 3'd1;
                if (w_bst_done) r_bst_active <= 1'b0;
            end else begin
                r_bst_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_act_ok) r_row[sdram_ba] <= sdram_a[ROW_BITS-1:0];
        if (w_rw_ok) begin
            r_bst_bank <= sdram_ba;
            r_bst_row  <= r_row[sdram_ba];
            r_bst_col  <= sdram_a[COL_BITS-1:0];
            r_bst_wr   <= (w_cmd == CMD_WR);
        end
    end

    // Read pipeline p1..p3: a WRITE flushes every pending read word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld_p1 <= 1'b0;
            r_rd_vld_p2 <= 1'b0;
            r_rd_vld_p3 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_gen_vld && !w_gen_wr;
            r_rd_vld_p2 <= r_rd_vld_p1 && !w_wr_start;
            r_rd_vld_p3 <= r_rd_vld_p2 && !w_wr_start;
        end
    end

    always_ff @(posedge clk) begin
        r_rd_addr_p1 <= w_gen_addr;
        r_rd_addr_p2 <= r_rd_addr_p1;
        r_rd_addr_p3 <= r_rd_addr_p2;
    end

    // RAM is read one cycle ahead of the CAS-latency tap so its registered output lines up
    assign w_ram_re   = (r_cl == 2'd3) ? r_rd_vld_p2  : r_rd_vld_p1;
    assign w_ram_addr = (r_cl == 2'd3) ? r_rd_addr_p2 : r_rd_addr_p1;
    assign w_due      = (r_cl == 2'd3) ? r_rd_vld_p3  : r_rd_vld_p2;

    always_ff @(posedge clk) begin
        if (w_gen_vld && w_gen_wr) r_mem[w_gen_addr] <= sdram_dq_in;
        if (w_ram_re) r_rdata <= r_mem[w_ram_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dq_out <= 16'd0;
            r_dq_oe  <= 1'b0;
        end else if (w_wr_start) begin
            r_dq_oe <= 1'b0;
        end else if (w_due) begin
            r_dq_oe  <= 1'b1;
            r_dq_out <= r_rdata;
        end else begin
            r_dq_oe <= 1'b0;
        end
    end

    assign sdram_dq_out  = r_dq_out;
    assign sdram_dq_oe   = r_dq_oe;
    assign cmd_error     = r_cmd_err;
    assign refresh_count = r_refresh;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder with a cycle-indexed behavioural model of the device
// and a few hand-computed literal expectations.
module tb_sdram_responder;
    localparam int ROW_BITS = 4;
    localparam int COL_BITS = 8;
    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, ras, cas, we;
    logic [1:0]  ba;
    logic [11:0] a;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe, cmd_error;
    logic [15:0] refresh_count;

    sdram_responder #(.CL_DEFAULT(2), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) dut (
        .clk(clk), .rst(rst), .sdram_cs_n(cs_n), .sdram_ras(ras), .sdram_cas(cas),
        .sdram_we(we), .sdram_ba(ba), .sdram_a(a), .sdram_dq_in(dq_in),
        .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe), .cmd_error(cmd_error),
        .refresh_count(refresh_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural device model
    logic [15:0] m_mem [int];
    bit          m_bank_act [4];
    int          m_row [4];
    int          m_cl, m_bl, m_ref;
    bit          s_rd [int];
    int          s_rd_addr [int];
    bit          s_wr [int];
    int          s_wr_addr [int];
    bit          b_live, b_wr;
    int          b_start, b_len, b_cl, b_bank;
    logic [15:0] m_last;
    bit          m_oe, m_err;
    logic [15:0] log_dq [int];
    bit          log_oe [int];

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin m_bank_act[b] = 0; m_row[b] = 0; end
        m_cl = 2; m_bl = 1; m_ref = 0; m_last = 16'd0; m_oe = 0; m_err = 0; b_live = 0;
        s_rd.delete(); s_rd_addr.delete(); s_wr.delete(); s_wr_addr.delete();
    endtask

    function automatic int word_addr(int bank, int row, int col, int k, int bl);
        int colk;
        colk = (col & ~(bl - 1)) | ((col + k) & (bl - 1));
        return (bank << (ROW_BITS + COL_BITS)) | (row << COL_BITS) | colk;
    endfunction

    task automatic terminate(int c);
        if (b_live) begin
            for (int k = 0; k < b_len; k++)
                if (b_start + k >= c) begin
                    if (b_wr) s_wr.delete(b_start + k);
                    else      s_rd.delete(b_start + b_cl + k);
                end
            b_live = 0;
        end
    endtask

    task automatic model_edge();
        int  c;
        bit  err, any_act, in_burst;
        logic [2:0] op;
        c = cyc;
        err = 0;
        op = cs_n ? C_NOP : {ras, cas, we};
        any_act = m_bank_act[0] | m_bank_act[1] | m_bank_act[2] | m_bank_act[3];
        in_burst = b_live && (b_start + b_len - 1 >= c);
        case (op)
            C_ACT: if (m_bank_act[ba]) err = 1;
                   else begin m_bank_act[ba] = 1; m_row[ba] = int'(a[ROW_BITS-1:0]); end
            C_RD, C_WR: begin
                if (!m_bank_act[ba]) err = 1;
                else begin
                    terminate(c);
                    if (op == C_WR)
                        foreach (s_rd[t]) if (t >= c) s_rd.delete(t);
                    b_live = 1; b_wr = (op == C_WR); b_start = c; b_len = m_bl;
                    b_cl = m_cl; b_bank = ba;
                    for (int k = 0; k < m_bl; k++) begin
                        if (b_wr) begin
                            s_wr[c + k] = 1;
                            s_wr_addr[c + k] = word_addr(ba, m_row[ba], int'(a[COL_BITS-1:0]), k, m_bl);
                        end else begin
                            s_rd[c + m_cl + k] = 1;
                            s_rd_addr[c + m_cl + k] = word_addr(ba, m_row[ba], int'(a[COL_BITS-1:0]), k, m_bl);
                        end
                    end
                end
            end
            C_PRE: begin
                if (in_burst && (a[10] || int'(ba) == b_bank)) terminate(c);
                for (int b = 0; b < 4; b++) if (a[10] || int'(ba) == b) m_bank_act[b] = 0;
            end
            C_REF: if (any_act) err = 1; else m_ref = (m_ref + 1) & 16'hFFFF;
            C_MRS: begin
                if (any_act || !(a[6:4] == 3'd2 || a[6:4] == 3'd3) || a[2:0] > 3'd3) err = 1;
                else begin m_cl = int'(a[6:4]); m_bl = 1 << a[1:0]; end
            end
            C_BST: if (!in_burst) err = 1; else terminate(c);
            default: ;
        endcase
        if (s_rd.exists(c)) begin m_oe = 1; m_last = m_mem[s_rd_addr[c]]; end
        else m_oe = 0;
        if (s_wr.exists(c)) m_mem[s_wr_addr[c]] = dq_in;
        m_err = err;
    endtask

    task automatic compare();
        chk("dq_oe", {15'd0, dq_oe}, {15'd0, m_oe});
        chk("dq_out", dq_out, m_last);
        chk("cmd_error", {15'd0, cmd_error}, {15'd0, m_err});
        chk("refresh_count", refresh_count, 16'(m_ref));
        log_dq[cyc] = dq_out;
        log_oe[cyc] = dq_oe;
    endtask

    // One clock: drive after a falling edge, update model at the rising edge, compare at the next fall
    task automatic step(bit sel, logic [2:0] op, logic [1:0] b, logic [11:0] ad, logic [15:0] d);
        cs_n = ~sel; {ras, cas, we} = op; ba = b; a = ad; dq_in = d;
        @(posedge clk);
        cyc++;
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic cmd(logic [2:0] op, logic [1:0] b, logic [11:0] ad, logic [15:0] d);
        step(1'b1, op, b, ad, d);
    endtask

    task automatic nops(int n);
        for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 12'd0, 16'd0);
    endtask

    function automatic int oe_count(int from, int to);
        int n = 0;
        for (int t = from; t <= to; t++) if (log_oe.exists(t) && log_oe[t]) n++;
        return n;
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        model_reset();
        nops(2);
        rst = 1'b0;
        nops(1);

        // CL2 BL4 write then wrapping read
        cmd(C_MRS, 2'd0, 12'h022, 16'd0);
        cmd(C_ACT, 2'd1, 12'h003, 16'd0);
        cmd(C_WR,  2'd1, 12'h004, 16'h1111);
        cmd(C_NOP, 2'd0, 12'h000, 16'h2222);
        cmd(C_NOP, 2'd0, 12'h000, 16'h3333);
        cmd(C_NOP, 2'd0, 12'h000, 16'h4444);
        nops(2);
        cmd(C_RD, 2'd1, 12'h005, 16'd0);
        n = cyc;
        nops(7);
        chk("bl4_w0", log_dq[n + 2], 16'h2222);
        chk("bl4_w1", log_dq[n + 3], 16'h3333);
        chk("bl4_w2", log_dq[n + 4], 16'h4444);
        chk("bl4_w3", log_dq[n + 5], 16'h1111);
        chk("bl4_oe_cnt", 16'(oe_count(n, n + 7)), 16'd4);
        chk("bl4_hold", log_dq[n + 7], 16'h1111);

        // CL3 BL1, then an invalid mode that must leave CL at 3
        cmd(C_PRE, 2'd0, 12'h400, 16'd0);
        cmd(C_MRS, 2'd0, 12'h030, 16'd0);
        cmd(C_ACT, 2'd1, 12'h003, 16'd0);
        cmd(C_RD,  2'd1, 12'h006, 16'd0);
        n = cyc;
        nops(4);
        chk("cl3_early", {15'd0, log_oe[n + 2]}, 16'd0);
        chk("cl3_word", log_dq[n + 3], 16'h3333);
        chk("cl3_oe_cnt", 16'(oe_count(n, n + 4)), 16'd1);
        cmd(C_BST, 2'd0, 12'h000, 16'd0);
        chk("bst_idle_err", {15'd0, cmd_error}, 16'd1);
        cmd(C_PRE, 2'd0, 12'h400, 16'd0);
        cmd(C_MRS, 2'd0, 12'h040, 16'd0);
        chk("mrs_bad_err", {15'd0, cmd_error}, 16'd1);
        cmd(C_ACT, 2'd1, 12'h003, 16'd0);
        cmd(C_RD,  2'd1, 12'h007, 16'd0);
        n = cyc;
        nops(4);
        chk("cl_kept_word", log_dq[n + 3], 16'h4444);
        chk("cl_kept_early", {15'd0, log_oe[n + 2]}, 16'd0);
        cmd(C_MRS, 2'd0, 12'h020, 16'd0);

        // Illegal command cases; precharge of idle bank and deselect are harmless
        cmd(C_PRE, 2'd1, 12'h000, 16'd0);
        cmd(C_PRE, 2'd2, 12'h000, 16'd0);
        chk("pre_idle_ok", {15'd0, cmd_error}, 16'd0);
        step(1'b0, C_RD, 2'd2, 12'h000, 16'd0);
        chk("desel_ok", {15'd0, cmd_error}, 16'd0);
        cmd(C_RD, 2'd2, 12'h000, 16'd0);
        n = cyc;
        chk("rd_idle_err", {15'd0, cmd_error}, 16'd1);
        nops(4);
        chk("rd_idle_pulse", {15'd0, log_oe[n + 1] | cmd_error}, 16'd0);
        chk("rd_idle_oe", 16'(oe_count(n, n + 4)), 16'd0);
        cmd(C_ACT, 2'd0, 12'h000, 16'd0);
        chk("act_first_ok", {15'd0, cmd_error}, 16'd0);
        cmd(C_ACT, 2'd0, 12'h000, 16'd0);
        chk("act_twice_err", {15'd0, cmd_error}, 16'd1);

        // Refresh counting
        cmd(C_PRE, 2'd0, 12'h400, 16'd0);
        cmd(C_REF, 2'd0, 12'h000, 16'd0);
        cmd(C_REF, 2'd0, 12'h000, 16'd0);
        cmd(C_REF, 2'd0, 12'h000, 16'd0);
        chk("ref_cnt3", refresh_count, 16'd3);
        cmd(C_ACT, 2'd0, 12'h000, 16'd0);
        cmd(C_REF, 2'd0, 12'h000, 16'd0);
        chk("ref_act_err", {15'd0, cmd_error}, 16'd1);
        chk("ref_act_cnt", refresh_count, 16'd3);

        // CL2 BL8: write, read cut by BURST STOP, read cut by WRITE
        cmd(C_PRE, 2'd0, 12'h400, 16'd0);
        cmd(C_MRS, 2'd0, 12'h023, 16'd0);
        cmd(C_ACT, 2'd0, 12'h001, 16'd0);
        cmd(C_WR,  2'd0, 12'h010, 16'hA000);
        for (int k = 1; k < 8; k++) cmd(C_NOP, 2'd0, 12'h000, 16'hA000 + 16'(k));
        nops(2);
        cmd(C_RD,  2'd0, 12'h010, 16'd0);
        n = cyc;
        cmd(C_NOP, 2'd0, 12'h000, 16'd0);
        cmd(C_BST, 2'd0, 12'h000, 16'd0);
        chk("bst_ok", {15'd0, cmd_error}, 16'd0);
        nops(8);
        chk("bst_w0", log_dq[n + 2], 16'hA000);
        chk("bst_w1", log_dq[n + 3], 16'hA001);
        chk("bst_oe_cnt", 16'(oe_count(n, n + 10)), 16'd2);
        cmd(C_RD, 2'd0, 12'h010, 16'd0);
        n = cyc;
        cmd(C_WR, 2'd0, 12'h020, 16'hB000);
        for (int k = 1; k < 8; k++) cmd(C_NOP, 2'd0, 12'h000, 16'hB000 + 16'(k));
        nops(3);
        chk("wr_cut_oe", 16'(oe_count(n, n + 11)), 16'd0);

        // Reset during the fourth word of a BL8 read
        cmd(C_RD, 2'd0, 12'h010, 16'd0);
        n = cyc;
        nops(5);
        chk("pre_rst_oe", {15'd0, log_oe[n + 5]}, 16'd1);
        chk("pre_rst_w3", log_dq[n + 5], 16'hA003);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_oe", {15'd0, dq_oe}, 16'd0);
        chk("rst_dq", dq_out, 16'd0);
        chk("rst_refresh", refresh_count, 16'd0);
        nops(2);
        rst = 1'b0;
        nops(1);
        cmd(C_RD, 2'd0, 12'h010, 16'd0);
        chk("rd_after_rst_err", {15'd0, cmd_error}, 16'd1);
        nops(4);
        chk("rst_no_words", 16'(oe_count(n + 6, cyc)), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
